cmos_capture: RTL and testbench
===============================

# cmos_capture

Pixel capture stage directly downstream of the SCCB camera-init block. Once `init_done` reports that camera register configuration is complete, it samples the OV-series DVP bus (PCLK/VSYNC/HREF/D[7:0]) in the 50 MHz system domain. It discards the first frames while the sensor settles, then assembles byte pairs into RGB565 pixels with x/y coordinates and frame/line markers for the frame-buffer writer.

## Interface
- `H_ACTIVE`, 640: pixels per line accepted; extra pixels are dropped.
- `V_ACTIVE`, 480: lines per frame accepted; extra lines are dropped.
- `SKIP_FRAMES`, 10: complete frames discarded after `init_done` rises (1..255).
- `clk` in 1: 50 MHz system clock.
- `rst` in 1: synchronous, active-high reset.
- `init_done` in 1: level; high = camera configuration complete (driven from `init_ov_done`).
- `cam_pclk` in 1: camera pixel clock, asynchronous; ≤ 12.5 MHz.
- `cam_vsync` in 1: frame sync, asynchronous; high = vertical blanking.
- `cam_href` in 1: line-valid, asynchronous.
- `cam_data` in 8: pixel byte, asynchronous.
- `pix_valid` out 1: one-cycle strobe; `pix_data`, `pix_x` and `pix_y` are valid.
- `pix_data` out 16: RGB565 pixel.
- `pix_x` out 11: column, 0..H_ACTIVE-1.
- `pix_y` out 10: row, 0..V_ACTIVE-1.
- `pix_sof` out 1: high with `pix_valid` for pixel (0,0).
- `pix_eol` out 1: high with `pix_valid` for column H_ACTIVE-1.
- `frame_done` out 1: one-cycle pulse at the end of every captured frame.
- `odd_err` out 1: sticky; set when a line ends on an unpaired byte. Cleared only by `rst`.

## Operation
- Input sync: `cam_pclk`, `cam_vsync`, `cam_href` and `cam_data` each pass through an identical 2-flop chain, so all four stay aligned.
  - PCLK rising edge = sync stage 2 high and a stage-3 history flop low.
  - All sampling uses the stage-2 values of that same cycle.
- `vs_rise` / `vs_fall` are edge detects on synced VSYNC in the `clk` domain.
- FSM states, evaluated in priority order:
  - `init_done` low in any state → IDLE; this aborts a frame in progress with no `frame_done`.
  - IDLE: clear the skip counter. Go to SKIP when `init_done` is high.
  - SKIP: count `vs_rise`. Go to WAIT_VS when the count reaches SKIP_FRAMES.
  - WAIT_VS: go to CAPTURE on `vs_fall`. Clear x, y, byte phase and line-active.
  - CAPTURE: go to WAIT_VS on `vs_rise` and pulse `frame_done` in that cycle.
- Byte assembly (CAPTURE only, on each PCLK edge with synced HREF high):
  - Phase 0 latches the high byte; phase 1 forms the pixel {hi, data}.
  - A phase-1 edge issues a pixel only if x < H_ACTIVE and y < V_ACTIVE; x increments (saturates at H_ACTIVE).
- Line end: synced HREF falling edge while line-active.
  - x ← 0; y increments (saturates at V_ACTIVE).
  - If phase = 1 at that point, set `odd_err` and drop the held byte. Phase ← 0.
- VSYNC rising in mid-line: treated as end of frame. The partial line is kept, and the held byte is dropped without `odd_err`.
- Pixels do not change during blanking. `pix_data`, `pix_x` and `pix_y` hold their last values between strobes.

## Timing
- Reset values: all outputs 0, FSM in IDLE, all counters 0, sync chains 0.
- Latency:
  - PCLK rising edge at the pin → edge detect in cycle 3 (sync ×2, then compare).
  - `pix_valid` is asserted in cycle 4, registered.
  - `pix_data`, `pix_x`, `pix_y`, `pix_sof` and `pix_eol` are registered in the same cycle as `pix_valid`.
- Minimum spacing of `pix_valid` = 2 PCLK periods (8 clk at 12.5 MHz). There is no backpressure, so the consumer must always accept.
- `frame_done` and `pix_valid` are never high in the same cycle. A `vs_rise` takes priority over any PCLK edge detected in the same cycle, and that edge is dropped.
- `rst` mid-frame: outputs drop to 0 in the next cycle. The full SKIP_FRAMES count is re-run after `init_done` is seen high.

## Configuration
- `CMOS_CAPTURE_BYTE_SWAP_EN`:
  - Defined: the phase-0 byte is the low byte and `pix_data` = {data, lo}.
  - Undefined (default): phase-0 byte is high; `pix_data` = {hi, data}.
  - Timing and counters are identical either way.

## Test plan
- Reset and gating:
  - After `rst`, with `init_done` = 0 and 3 frames of traffic → no `pix_valid`, no `frame_done`, all outputs 0.
- Skip count:
  - SKIP_FRAMES = 2, `init_done` = 1, 4 frames of 4×2 pixels → exactly 2 frames captured, 2 `frame_done` pulses, 16 `pix_valid` strobes.
- Pixel assembly:
  - Bytes 0xF8, 0x1F → `pix_data` = 0xF81F, or 0x1FF8 with `CMOS_CAPTURE_BYTE_SWAP_EN`.
  - First pixel of the frame has `pix_sof` = 1 and x = 0, y = 0.
  - `pix_eol` is high at x = H_ACTIVE-1.
- Bounds:
  - H_ACTIVE = 4, line of 6 pixels → 4 strobes (x = 0..3) and the next line starts at x = 0.
  - V_ACTIVE = 2, 3 lines → no strobes with y = 2.
- Odd line:
  - Line of 7 bytes → 3 pixels, then `odd_err` = 1 and stays set.
  - The next line's first pixel is correctly paired.
- Abort:
  - `init_done` dropped mid-line → FSM in IDLE, no `frame_done`.
  - Re-assert `init_done` → SKIP_FRAMES frames discarded before capture resumes.

Source files
------------

// File: rtl/cmos_capture.sv
// ---------------------------------------------------------------------------
// cmos_capture
//
// Pixel capture stage for an OV-series DVP camera. It sits directly after
// the SCCB camera-init block. Once init_done is high it samples the camera
// bus (PCLK/VSYNC/HREF/D[7:0]) in the 50 MHz system clock domain. It then
// discards SKIP_FRAMES frames while the sensor settles. After that it
// assembles byte pairs into RGB565 pixels, tagged with x/y coordinates and
// frame/line markers, for the frame-buffer writer.
//
// Parameters:
//   H_ACTIVE    : pixels per line accepted; extra pixels are dropped.
//   V_ACTIVE    : lines per frame accepted; extra lines are dropped.
//   SKIP_FRAMES : complete frames discarded after init_done rises (1..255).
//
// Ports:
//   clk        in   50 MHz system clock
//   rst        in   synchronous, active-high reset
//   init_done  in   level; high once camera configuration is complete
//   cam_pclk   in   camera pixel clock (asynchronous, <= 12.5 MHz)
//   cam_vsync  in   frame sync (asynchronous); high = vertical blanking
//   cam_href   in   line valid (asynchronous)
//   cam_data   in   [7:0] pixel byte (asynchronous)
//   pix_valid  out  one-cycle strobe; pix_data/pix_x/pix_y are valid
//   pix_data   out  [15:0] RGB565 pixel
//   pix_x      out  [10:0] column, 0..H_ACTIVE-1
//   pix_y      out  [9:0]  row, 0..V_ACTIVE-1
//   pix_sof    out  high with pix_valid for pixel (0,0)
//   pix_eol    out  high with pix_valid for column H_ACTIVE-1
//   frame_done out  one-cycle pulse at the end of every captured frame
//   odd_err    out  sticky; a line ended on an unpaired byte (cleared by rst)
//   fsm_state  out  [1:0] current FSM state (0 IDLE, 1 SKIP, 2 WAIT_VS,
//                   3 CAPTURE), exported for debug
//
// Handshake: pix_valid is a pure strobe with no ready input. The consumer
// must accept every strobe. Strobes are at least two PCLK periods apart.
//
// Optional build macro CMOS_CAPTURE_BYTE_SWAP_EN:
//   - When defined, the first byte of a pair is the low byte, so
//     pix_data = {second, first}.
//   - When undefined (the default), pix_data = {first, second}.
// ---------------------------------------------------------------------------
module cmos_capture #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        cam_pclk,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    output logic        pix_valid,
    output logic [15:0] pix_data,
    output logic [10:0] pix_x,
    output logic [9:0]  pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_done,
    output logic        odd_err,
    output logic [1:0]  fsm_state
);

    localparam logic [10:0] H_MAX     = 11'(H_ACTIVE);
    localparam logic [10:0] H_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [9:0]  V_MAX     = 10'(V_ACTIVE);
    localparam logic [7:0]  SKIP_LAST = 8'(SKIP_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SKIP    = 2'd1,
        ST_WAIT_VS = 2'd2,
        ST_CAPTURE = 2'd3
    } state_t;

    state_t state, state_next;

    // ------------------------------------------------------------------
    // Input synchronisers. All four camera signals take the same two-flop
    // path, so a PCLK edge and the data/HREF it qualifies arrive together.
    // The third PCLK/VSYNC/HREF flop only keeps history for edge detection.
    // ------------------------------------------------------------------
    logic       pclk_s1, pclk_s2, pclk_s3;
    logic       vs_s1, vs_s2, vs_s3;
    logic       href_s1, href_s2, href_s3;
    logic [7:0] data_s1, data_s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            pclk_s1 <= 1'b0; pclk_s2 <= 1'b0; pclk_s3 <= 1'b0;
            vs_s1   <= 1'b0; vs_s2   <= 1'b0; vs_s3   <= 1'b0;
            href_s1 <= 1'b0; href_s2 <= 1'b0; href_s3 <= 1'b0;
            data_s1 <= 8'd0; data_s2 <= 8'd0;
        end else begin
            pclk_s1 <= cam_pclk;  pclk_s2 <= pclk_s1; pclk_s3 <= pclk_s2;
            vs_s1   <= cam_vsync; vs_s2   <= vs_s1;   vs_s3   <= vs_s2;
            href_s1 <= cam_href;  href_s2 <= href_s1; href_s3 <= href_s2;
            data_s1 <= cam_data;  data_s2 <= data_s1;
        end
    end

    logic pclk_rise, vs_rise, vs_fall, href_fall;

    assign pclk_rise = pclk_s2 & ~pclk_s3;
    assign vs_rise   = vs_s2 & ~vs_s3;
    assign vs_fall   = ~vs_s2 & vs_s3;
    assign href_fall = ~href_s2 & href_s3;

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    logic [7:0] skip_cnt;
    logic       skip_clr, skip_inc, cap_clr, frame_end, cap_en;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        skip_clr   = (state == ST_IDLE);
        skip_inc   = 1'b0;
        cap_clr    = 1'b0;
        frame_end  = 1'b0;
        cap_en     = 1'b0;
        if (!init_done) begin
            // Losing configuration aborts everything, with no frame_done.
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_SKIP;
                end
                ST_SKIP: begin
                    if (vs_rise) begin
                        skip_inc = 1'b1;
                        if (skip_cnt == SKIP_LAST) state_next = ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    if (vs_fall) begin
                        cap_clr    = 1'b1;
                        state_next = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    // A VSYNC rise wins over a PCLK edge seen in the same
                    // cycle. That edge is dropped, so frame_done and
                    // pix_valid can never coincide.
                    if (vs_rise) begin
                        frame_end  = 1'b1;
                        state_next = ST_WAIT_VS;
                    end else begin
                        cap_en = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    assign fsm_state = state;

    // ------------------------------------------------------------------
    // Byte assembly and coordinate tracking
    // ------------------------------------------------------------------
    logic [10:0] x;
    logic [9:0]  y;
    logic        phase;
    logic        line_active;
    logic [7:0]  held;
    logic [15:0] assembled;

`ifdef CMOS_CAPTURE_BYTE_SWAP_EN
    assign assembled = {data_s2, held};
`else
    assign assembled = {held, data_s2};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            skip_cnt    <= 8'd0;
            x           <= 11'd0;
            y           <= 10'd0;
            phase       <= 1'b0;
            line_active <= 1'b0;
            held        <= 8'd0;
            pix_valid   <= 1'b0;
            pix_data    <= 16'd0;
            pix_x       <= 11'd0;
            pix_y       <= 10'd0;
            pix_sof     <= 1'b0;
            pix_eol     <= 1'b0;
            frame_done  <= 1'b0;
            odd_err     <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            pix_sof    <= 1'b0;
            pix_eol    <= 1'b0;
            frame_done <= frame_end;

            if (skip_clr)      skip_cnt <= 8'd0;
            else if (skip_inc) skip_cnt <= skip_cnt + 8'd1;

            if (cap_clr) begin
                x <= 11'd0;
                y <= 10'd0;
            end
            // At a frame end mid-line the partial line is kept. The held
            // byte is discarded silently, without raising odd_err.
            if (cap_clr || frame_end) begin
                phase       <= 1'b0;
                line_active <= 1'b0;
            end

            if (cap_en) begin
                if (href_s2) line_active <= 1'b1;

                if (pclk_rise && href_s2) begin
                    if (!phase) begin
                        held  <= data_s2;
                        phase <= 1'b1;
                    end else begin
                        phase <= 1'b0;
                        if ((x < H_MAX) && (y < V_MAX)) begin
                            pix_valid <= 1'b1;
                            pix_data  <= assembled;
                            pix_x     <= x;
                            pix_y     <= y;
                            pix_sof   <= (x == 11'd0) && (y == 10'd0);
                            pix_eol   <= (x == H_LAST);
                        end
                        if (x < H_MAX) x <= x + 11'd1;
                    end
                end else if (href_fall && line_active) begin
                    x <= 11'd0;
                    if (y < V_MAX) y <= y + 10'd1;
                    if (phase) odd_err <= 1'b1;
                    phase       <= 1'b0;
                    line_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_cmos_capture.sv
// ---------------------------------------------------------------------------
// tb_cmos_capture
//
// Directed testbench for cmos_capture. The DUT is built with a small
// geometry: H_ACTIVE=4, V_ACTIVE=2, SKIP_FRAMES=2.
//
// The stimulus tasks drive the DVP bus. Each time they send a pixel that
// should be captured, they push the expected {sof, eol, y, x, data} record
// into exp_q. A separate monitor pops exp_q on every pix_valid and compares
// the record. It also counts strobes and frame_done pulses, and the main
// sequence checks those counts against hand-computed totals.
// ---------------------------------------------------------------------------
module tb_cmos_capture;

    localparam int H = 4;
    localparam int V = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        init_done = 1'b0;
    logic        cam_pclk = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        cam_href = 1'b0;
    logic [7:0]  cam_data = 8'd0;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        pix_sof;
    logic        pix_eol;
    logic        frame_done;
    logic        odd_err;
    logic [1:0]  fsm_state;

    cmos_capture #(
        .H_ACTIVE    (H),
        .V_ACTIVE    (V),
        .SKIP_FRAMES (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .init_done  (init_done),
        .cam_pclk   (cam_pclk),
        .cam_vsync  (cam_vsync),
        .cam_href   (cam_href),
        .cam_data   (cam_data),
        .pix_valid  (pix_valid),
        .pix_data   (pix_data),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .frame_done (frame_done),
        .odd_err    (odd_err),
        .fsm_state  (fsm_state)
    );

    // ---------------- clock ----------------
    always #10 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [38:0] exp_q[$];
    int          checks   = 0;
    int          errors   = 0;
    int          pix_cnt  = 0;
    int          done_cnt = 0;
    int          sof_cnt  = 0;
    int          eol_cnt  = 0;
    logic [15:0] first_pix = 16'd0;
    bit          special   = 1'b0;
    logic [38:0] mon_got;
    logic [38:0] mon_exp;

`ifdef CMOS_CAPTURE_BYTE_SWAP_EN
    localparam logic [15:0] FIRST_PIX = 16'h1FF8;
`else
    localparam logic [15:0] FIRST_PIX = 16'hF81F;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (pix_valid) begin
            mon_got = {pix_sof, pix_eol, pix_y, pix_x, pix_data};
            if (pix_cnt == 0) first_pix = pix_data;
            pix_cnt++;
            if (pix_sof) sof_cnt++;
            if (pix_eol) eol_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pixel: unexpected strobe sof=%0d eol=%0d y=%0d x=%0d data=%h, expected none",
                         pix_sof, pix_eol, pix_y, pix_x, pix_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    errors++;
                    $display("FAIL pixel: got sof=%0d eol=%0d y=%0d x=%0d data=%h expected sof=%0d eol=%0d y=%0d x=%0d data=%h",
                             mon_got[38], mon_got[37], mon_got[36:27], mon_got[26:16], mon_got[15:0],
                             mon_exp[38], mon_exp[37], mon_exp[36:27], mon_exp[26:16], mon_exp[15:0]);
                end
            end
        end
        if (frame_done) begin
            done_cnt++;
            checks++;
            if (pix_valid !== 1'b0) begin
                errors++;
                $display("FAIL done_vs_valid: pix_valid=%0b with frame_done, expected 0", pix_valid);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        cam_data = b;
        #80;
        cam_pclk = 1'b1;
        #80;
        cam_pclk = 1'b0;
    endtask

    // Sends one line of nbytes. ln is the line index within the frame.
    // Captured pixels are pushed as expectations. From byte abort_at on,
    // init_done is dropped and nothing further is expected.
    task automatic send_line(input int nbytes, input int ln, input bit cap,
                             input logic [7:0] base, input int abort_at);
        logic [7:0]  b;
        logic [7:0]  hi;
        logic [15:0] p;
        logic        s;
        logic        e;
        bit          c;
        int          px;
        c  = cap;
        hi = 8'd0;
        cam_href = 1'b1;
        for (int j = 0; j < nbytes; j++) begin
            if (j == abort_at) begin
                init_done = 1'b0;
                c = 1'b0;
            end
            b = base + 8'(j * 17);
            if (special && j == 0) b = 8'hF8;
            if (special && j == 1) b = 8'h1F;
            if (j % 2 == 0) begin
                hi = b;
            end else begin
                px = j / 2;
                if (c && px < H && ln < V) begin
`ifdef CMOS_CAPTURE_BYTE_SWAP_EN
                    p = {b, hi};
`else
                    p = {hi, b};
`endif
                    s = (px == 0) && (ln == 0);
                    e = (px == H - 1);
                    exp_q.push_back({s, e, 10'(ln), 11'(px), p});
                end
            end
            send_byte(b);
        end
        cam_href = 1'b0;
        special = 1'b0;
        #320;
    endtask

    task automatic vsync_pulse();
        cam_vsync = 1'b1;
        #400;
        cam_vsync = 1'b0;
        #400;
    endtask

    // A frame is its lines followed by the VSYNC blanking pulse.
    task automatic send_frame(input int nlines, input int nbytes, input bit cap,
                              input logic [7:0] base);
        for (int l = 0; l < nlines; l++)
            send_line(nbytes, l, cap, base + 8'(l * 40), -1);
        vsync_pulse();
    endtask

    task automatic drain();
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain", 32'(exp_q.size()), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        // Reset state
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_pix_valid",  32'(pix_valid), 0);
        check("rst_pix_data",   32'(pix_data), 0);
        check("rst_pix_x",      32'(pix_x), 0);
        check("rst_pix_y",      32'(pix_y), 0);
        check("rst_pix_sof",    32'(pix_sof), 0);
        check("rst_pix_eol",    32'(pix_eol), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_odd_err",    32'(odd_err), 0);
        check("rst_state",      32'(fsm_state), 0);

        // Gating: traffic with init_done low produces nothing
        for (int f = 0; f < 3; f++) send_frame(2, 8, 1'b0, 8'(f * 9));
        @(negedge clk);
        check("gate_pix_cnt",  32'(pix_cnt), 0);
        check("gate_done_cnt", 32'(done_cnt), 0);
        check("gate_state",    32'(fsm_state), 0);
        check("gate_pix_data", 32'(pix_data), 0);

        // Skip count: two frames discarded, two captured (4x2 each)
        init_done = 1'b1;
        repeat (3) @(negedge clk);
        check("skip_state", 32'(fsm_state), 1);
        send_frame(2, 8, 1'b0, 8'h10);
        send_frame(2, 8, 1'b0, 8'h20);
        check("skip_done_state", 32'(fsm_state), 3);
        check("skip_no_pixels",  32'(pix_cnt), 0);
        special = 1'b1;
        send_frame(2, 8, 1'b1, 8'h30);
        send_frame(2, 8, 1'b1, 8'h50);
        drain();
        check("cap_pix_cnt",   32'(pix_cnt), 16);
        check("cap_done_cnt",  32'(done_cnt), 2);
        check("cap_first_pix", 32'(first_pix), 32'(FIRST_PIX));
        check("cap_sof_cnt",   32'(sof_cnt), 2);
        check("cap_eol_cnt",   32'(eol_cnt), 4);

        // Bounds: 3 lines of 6 pixels -> 2 lines of 4 strobes
        send_frame(3, 12, 1'b1, 8'h70);
        drain();
        check("bound_pix_cnt",  32'(pix_cnt), 24);
        check("bound_done_cnt", 32'(done_cnt), 3);
        check("bound_eol_cnt",  32'(eol_cnt), 6);
        check("bound_odd_err",  32'(odd_err), 0);

        // Odd line: 7 bytes -> 3 pixels and odd_err, next line pairs cleanly
        send_line(7, 0, 1'b1, 8'h90, -1);
        send_line(8, 1, 1'b1, 8'hA0, -1);
        vsync_pulse();
        drain();
        check("odd_pix_cnt",  32'(pix_cnt), 31);
        check("odd_done_cnt", 32'(done_cnt), 4);
        check("odd_err_set",  32'(odd_err), 1);
        send_frame(2, 8, 1'b1, 8'hB0);
        drain();
        check("odd_err_sticky", 32'(odd_err), 1);
        check("odd2_pix_cnt",   32'(pix_cnt), 39);

        // Abort: drop init_done mid-line after one pixel
        send_line(8, 0, 1'b1, 8'hC0, 2);
        vsync_pulse();
        drain();
        check("abort_state",    32'(fsm_state), 0);
        check("abort_done_cnt", 32'(done_cnt), 5);
        check("abort_pix_cnt",  32'(pix_cnt), 40);

        // Resume: full skip count re-run before capture
        init_done = 1'b1;
        repeat (3) @(negedge clk);
        check("resume_state", 32'(fsm_state), 1);
        send_frame(2, 8, 1'b0, 8'hD0);
        send_frame(2, 8, 1'b0, 8'hE0);
        check("resume_skip_pix", 32'(pix_cnt), 40);
        send_frame(2, 8, 1'b1, 8'hF0);
        drain();
        check("resume_pix_cnt",  32'(pix_cnt), 48);
        check("resume_done_cnt", 32'(done_cnt), 6);
        check("final_odd_err",   32'(odd_err), 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
